// File: rtl/pir_cond.sv
// pir_cond: HC-SR501 PIR input conditioner (sync, warm-up blanking, glitch filter, retriggerable hold).
// Define PIR_EVT_CNT_EN to build the saturating 16-bit qualified-detection counter on evt_cnt.
module pir_cond #(
    parameter int unsigned WARMUP_CYC = 1_500_000_000,
    parameter int unsigned FILT_CYC   = 50_000,
    parameter int unsigned HOLD_CYC   = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pir_raw,
    output logic        hum_det,
    output logic        det_pulse,
    output logic        warm_done,
    output logic [15:0] evt_cnt
);
    localparam int unsigned MAX_WF = (WARMUP_CYC > FILT_CYC) ? WARMUP_CYC : FILT_CYC;
    localparam int unsigned MAX_C  = (MAX_WF > HOLD_CYC) ? MAX_WF : HOLD_CYC;
    localparam int CW = $clog2(MAX_C + 1);
    typedef enum logic [2:0] {WARMUP, IDLE, QUALIFY, ACTIVE, HOLD} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic pir_m, pir_s;
    logic hum_n, pulse_n, warm_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pir_m     <= 1'b0;
            pir_s     <= 1'b0;
            state     <= WARMUP;
            cnt       <= '0;
            hum_det   <= 1'b0;
            det_pulse <= 1'b0;
            warm_done <= 1'b0;
        end else begin
            pir_m     <= pir_raw;
            pir_s     <= pir_m;
            state     <= state_n;
            cnt       <= cnt_n;
            hum_det   <= hum_n;
            det_pulse <= pulse_n;
            warm_done <= warm_n;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            WARMUP:  state_n = (cnt == CW'(WARMUP_CYC - 1)) ? IDLE : WARMUP;
            IDLE:    state_n = pir_s ? QUALIFY : IDLE;
            QUALIFY: state_n = !pir_s ? IDLE : (cnt == CW'(FILT_CYC - 1)) ? ACTIVE : QUALIFY;
            ACTIVE:  state_n = pir_s ? ACTIVE : HOLD;
            HOLD:    state_n = pir_s ? ACTIVE : (cnt == CW'(HOLD_CYC - 1)) ? IDLE : HOLD;
            default: state_n = WARMUP;
        endcase
    end
    // IDLE and ACTIVE never consult the counter, so it is frozen there to avoid wrapping
    always_comb begin
        cnt_n   = (state_n != state) ? '0 : (state == IDLE || state == ACTIVE) ? cnt : cnt + 1'b1;
        hum_n   = (state_n == ACTIVE) || (state_n == HOLD);
        pulse_n = (state == QUALIFY) && (state_n == ACTIVE);
        warm_n  = state_n != WARMUP;
    end
`ifdef PIR_EVT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            evt_cnt <= 16'd0;
        else if (pulse_n && evt_cnt != 16'hFFFF)
            evt_cnt <= evt_cnt + 16'd1;
    end
`else
    assign evt_cnt = 16'd0;
`endif
endmodule
